// File: rtl/output_buffer_pkg.sv
// output_buffer_pkg: shared state type, default geometry and lane selector for the output buffer
package output_buffer_pkg;
  localparam int LANES = 8;
  localparam int LANE_BITS = 32;
  localparam int SLOTS = 4;
  localparam int LANE_W = $clog2(LANES);
  localparam int PTR_W = $clog2(SLOTS);
  localparam int OCC_W = PTR_W + 1;
  typedef enum logic {IDLE, SEND} state_t;
  function automatic logic [LANE_BITS-1:0] lane_sel(input logic [LANES*LANE_BITS-1:0] v, input logic [LANE_W-1:0] idx);
    return v[idx*LANE_BITS +: LANE_BITS];
  endfunction
endpackage

// File: rtl/output_buffer_fifo.sv
// vector_fifo: circular store of DEPTH wide vectors (push/pop, head, occupancy, full)
module vector_fifo import output_buffer_pkg::*; #(
  parameter int WIDTH = LANES * LANE_BITS,
  parameter int DEPTH = SLOTS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       full
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occupancy <= occupancy + OW'(push) - OW'(pop);
    end
  end
  assign head = mem[rd_ptr];
  assign full = occupancy == OW'(DEPTH);
endmodule

// File: rtl/output_buffer.sv
// output_buffer: stores pushed N-lane vectors and drains them lane by lane on a valid/ready stream, dropping and flagging pushes on overflow
module output_buffer import output_buffer_pkg::*; #(
  parameter int N = LANES,
  parameter int DATA_WIDTH = LANE_BITS,
  parameter int DEPTH = SLOTS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N*DATA_WIDTH-1:0]   vector_in,
  input  logic                      vector_valid,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      dout_last,
  output logic [$clog2(N)-1:0]      lane_idx,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic                      overflow,
  input  logic                      overflow_clear
);
  state_t state, state_nx;
  logic [N*DATA_WIDTH-1:0] head;
  logic full, xfer, done, push;
  vector_fifo #(.WIDTH(N*DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(done), .din(vector_in),
    .head(head), .occupancy(occupancy), .full(full)
  );
  assign dout_valid = state == SEND;
  assign xfer = dout_valid && dout_ready;
  assign done = xfer && lane_idx == LANE_W'(N - 1);
  assign push = vector_valid && (!full || done);
  assign dout_last = dout_valid && lane_idx == LANE_W'(N - 1);
  assign dout = dout_valid ? lane_sel(head, lane_idx) : '0;
  always_comb begin
    state_nx = state;
    state_nx = done ? ((occupancy > 1 || push) ? SEND : IDLE)
                    : ((dout_valid || occupancy != 0 || push) ? SEND : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lane_idx <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (xfer) lane_idx <= done ? '0 : lane_idx + 1'b1;
      if (vector_valid && !push) overflow <= 1'b1;
      else if (overflow_clear) overflow <= 1'b0;
    end
  end
endmodule
